// File: rtl/out_port_alloc_pkg.sv
// Shared NoC switch definitions: allocator FSM encoding, default port count
// and a helper for index widths.
package out_port_alloc_pkg;

  // Default number of input ports contending for one output port.
  localparam int NOC_IN_N = 5;

  // Output-port allocator states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // Width of a binary port index; never zero so single-port builds still elaborate.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_port_alloc_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// at or after ptr_i, wrapping from IN_N-1 to 0, as one-hot and binary index.
module rr_pick
  import out_port_alloc_pkg::*;
#(
  parameter int IN_N = NOC_IN_N
) (
  input  logic [IN_N-1:0]         req_i,
  input  logic [id_width(IN_N)-1:0] ptr_i,
  output logic [IN_N-1:0]         win_o,
  output logic [id_width(IN_N)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDW = id_width(IN_N);

  logic found;
  int   j;

  // Scan IN_N positions starting at the pointer; the first hit wins.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < IN_N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= IN_N) j = j - IN_N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = IDW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/out_port_alloc.sv
// out_port_alloc: wormhole output-port allocator. Round-robin arbitration in
// IDLE, lock held until the owner's tail flit transfers, then a one-cycle
// re-arbitration bubble.
// Optional: define ALLOC_LOCK_TIMEOUT_EN to release a lock whose owner has
// stopped requesting for TIMEOUT_CYC consecutive cycles.
//
// Handshake: a flit moves on a cycle where the owner requests (req_i[owner]),
// the downstream accepts (ready_i) and a grant is held; xfer_o flags exactly
// those cycles. Neither side may make the transfer depend on xfer_o.
module out_port_alloc
  import out_port_alloc_pkg::*;
#(
  parameter int IN_N        = NOC_IN_N,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [IN_N-1:0]           req_i,
  input  logic [IN_N-1:0]           tail_i,
  input  logic                      ready_i,
  output logic [IN_N-1:0]           grant_o,
  output logic [id_width(IN_N)-1:0] grant_id_o,
  output logic                      grant_vld_o,
  output logic                      xfer_o,
  output logic                      timeout_o,
  output logic                      dbg_state_o,
  output logic [id_width(IN_N)-1:0] dbg_ptr_o
);

  localparam int IDW = id_width(IN_N);

  alloc_state_e    state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IN_N-1:0] grant_q, grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            vld_q, vld_d;
  logic            rel;

  logic [IN_N-1:0] pick_win;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_pick #(.IN_N(IN_N)) u_rr_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef ALLOC_LOCK_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |8'(TIMEOUT_CYC);
`endif

  assign xfer_o      = vld_q & req_i[id_q] & ready_i;
  assign grant_o     = grant_q;
  assign grant_id_o  = id_q;
  assign grant_vld_o = vld_q;
  assign dbg_state_o = logic'(state_q);
  assign dbg_ptr_o   = ptr_q;
`ifdef ALLOC_LOCK_TIMEOUT_EN
  assign timeout_o   = to_q;
`else
  assign timeout_o   = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, hold the lock in LOCKED until release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    vld_d   = vld_q;
    rel     = 1'b0;
`ifdef ALLOC_LOCK_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          grant_d = pick_win;
          id_d    = pick_idx;
          vld_d   = 1'b1;
          ptr_d   = (pick_idx == IDW'(IN_N - 1)) ? '0 : pick_idx + IDW'(1);
`ifdef ALLOC_LOCK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_LOCKED: begin
        rel = xfer_o & tail_i[id_q];
`ifdef ALLOC_LOCK_TIMEOUT_EN
        // Count consecutive cycles the owner is silent; force release at the limit.
        if (!rel) begin
          if (req_i[id_q]) begin
            cnt_d = '0;
          end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            rel  = 1'b1;
            to_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
        if (rel) begin
          state_d = ST_IDLE;
          grant_d = '0;
          id_d    = '0;
          vld_d   = 1'b0;
`ifdef ALLOC_LOCK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any lock immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
`ifdef ALLOC_LOCK_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
`ifdef ALLOC_LOCK_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule
